// File: rtl/data_bus_unit.sv
// data_bus_unit: CPU data-bus slave with word RAM, TX FIFO drained over valid/ready, and STATUS register.
// Define DBU_CYCLE_COUNTER_EN to add a loadable free-running CYCLES register at 0xFF02.
module data_bus_unit #(
    parameter int RAM_AW  = 8,
    parameter int FIFO_AW = 2
) (
    input  logic        ck,
    input  logic        rst,
    input  logic [15:0] da,
    inout  wire  [15:0] dd,
    input  logic        rw,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam logic [FIFO_AW:0] PTR_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW:0] FULL_OCC = (FIFO_AW+1)'(1 << FIFO_AW);

    logic [15:0]      ram  [2**RAM_AW];
    logic [15:0]      fifo [2**FIFO_AW];
    logic             rw_q, rw_d, ovf_q, ovf_d;
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ;
    logic             wr_en, in_ram, push, pop, fifo_wr, empty, full;
    logic [15:0]      status, cyc_val, rd_data;

    always_comb begin
        wr_en    = !rw && rw_q;
        in_ram   = (da >> RAM_AW) == 16'd0;
        occ      = wr_ptr_q - rd_ptr_q;
        empty    = occ == '0;
        full     = occ == FULL_OCC;
        push     = wr_en && da == 16'hFF00;
        pop      = !empty && out_ready;
        // a push into a full FIFO only lands if the head leaves on the same edge
        fifo_wr  = push && (!full || pop);
        rw_d     = rw;
        wr_ptr_d = fifo_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        ovf_d    = (wr_en && da == 16'hFF01) ? 1'b0 : (push && !fifo_wr) ? 1'b1 : ovf_q;
        status   = {8'(occ), 5'd0, ovf_q, full, empty};
        rd_data  = in_ram ? ram[da[RAM_AW-1:0]] :
                   da == 16'hFF01 ? status :
                   da == 16'hFF02 ? cyc_val : 16'd0;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            rw_q     <= 1'b1;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            rw_q     <= rw_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge ck) begin
        if (wr_en && in_ram) ram[da[RAM_AW-1:0]] <= dd;
        if (fifo_wr) fifo[wr_ptr_q[FIFO_AW-1:0]] <= dd;
    end

`ifdef DBU_CYCLE_COUNTER_EN
    logic [15:0] cyc_q, cyc_d;
    always_comb cyc_d = (wr_en && da == 16'hFF02) ? dd : cyc_q + 16'd1;
    always_ff @(posedge ck) cyc_q <= rst ? 16'd0 : cyc_d;
    assign cyc_val = cyc_q;
`else
    assign cyc_val = 16'd0;
`endif

    assign dd        = rw ? rd_data : 16'hzzzz;
    assign out_data  = fifo[rd_ptr_q[FIFO_AW-1:0]];
    assign out_valid = !empty;
endmodule

// File: tb/tb_data_bus_unit.sv
// tb_data_bus_unit: directed and randomized checks of data_bus_unit against a queue-based model.
module tb_data_bus_unit;
    logic        ck = 0, rst = 1, rw = 1, out_ready = 0;
    logic [15:0] da = 0, tb_dd = 0;
    wire  [15:0] dd;
    logic [15:0] out_data;
    logic        out_valid;
    int          cmp = 0, bad = 0;

    logic [15:0] q [$];
    logic [15:0] ram_m [int];
    int          waddrs [$];
    bit          ovf = 0, m_rwq = 1;
    logic [15:0] cyc = 0;

    assign dd = rw ? 16'hzzzz : tb_dd;

    data_bus_unit dut (
        .ck(ck), .rst(rst), .da(da), .dd(dd), .rw(rw),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 ck = ~ck;

    function automatic logic [15:0] exp_read(logic [15:0] a);
        if (a < 16'h0100) return ram_m.exists(int'(a)) ? ram_m[int'(a)] : 16'hxxxx;
        if (a == 16'hFF01) return {8'(q.size()), 5'd0, ovf, q.size() == 4, q.size() == 0};
`ifdef DBU_CYCLE_COUNTER_EN
        if (a == 16'hFF02) return cyc;
`endif
        return 16'd0;
    endfunction

    // applies the current inputs to the model for the coming posedge, then moves to the next negedge
    task automatic tick();
        bit commit, full, pop;
        if (rst) begin
            q.delete();
            ovf = 0;
            cyc = 0;
            m_rwq = 1;
        end else begin
            commit = !rw && m_rwq;
            full = q.size() == 4;
            pop = q.size() > 0 && out_ready;
            if (pop) void'(q.pop_front());
            if (commit && da == 16'hFF00) begin
                if (full && !pop) ovf = 1;
                else q.push_back(tb_dd);
            end
            if (commit && da == 16'hFF01) ovf = 0;
            if (commit && da < 16'h0100) begin
                if (!ram_m.exists(int'(da))) waddrs.push_back(int'(da));
                ram_m[int'(da)] = tb_dd;
            end
`ifdef DBU_CYCLE_COUNTER_EN
            cyc = (commit && da == 16'hFF02) ? tb_dd : cyc + 16'd1;
`endif
            m_rwq = rw;
        end
        @(negedge ck);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        rw = 0; da = a; tb_dd = d;
        tick();
        rw = 1; da = 16'hFFFF;
        tick();
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        rw = 1; da = a;
        #1 v = dd;
        tick();
    endtask

    task automatic test_reset();
        logic [15:0] v;
        rst = 1; tick(); tick(); rst = 0;
        #1 cmp++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        rd(16'hFF01, v);
        cmp++;
        if (v !== 16'h0001) begin bad++; $display("FAIL reset_status got %h want 0001", v); end
    endtask

    task automatic test_ram();
        logic [15:0] v;
        wr(16'h0005, 16'h1234);
        rd(16'h0005, v);
        cmp++;
        if (v !== 16'h1234) begin bad++; $display("FAIL ram_rt got %h want 1234", v); end
        rd(16'h0300, v);
        cmp++;
        if (v !== 16'h0000) begin bad++; $display("FAIL ram_oor got %h want 0000", v); end
    endtask

    task automatic test_single_write();
        logic [15:0] v;
        rw = 0; da = 16'hFF00; tb_dd = 16'h00AA;
        tick();
        #1 cmp++;
        if (out_valid !== 1'b1 || out_data !== 16'h00AA) begin
            bad++; $display("FAIL single_head got v=%b d=%h want v=1 d=00aa", out_valid, out_data);
        end
        tick(); tick();
        rd(16'hFF01, v);
        cmp++;
        if (v !== 16'h0100) begin bad++; $display("FAIL single_status got %h want 0100", v); end
        out_ready = 1; tick(); out_ready = 0;
        #1 cmp++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got %b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        logic [15:0] v;
        out_ready = 0;
        for (int i = 1; i <= 5; i++) wr(16'hFF00, 16'(i));
        rd(16'hFF01, v);
        cmp++;
        if (v !== 16'h0406) begin bad++; $display("FAIL ovf_status got %h want 0406", v); end
        wr(16'hFF01, 16'h5A5A);
        rd(16'hFF01, v);
        cmp++;
        if (v !== 16'h0402) begin bad++; $display("FAIL ovf_clear got %h want 0402", v); end
        out_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            #1 cmp++;
            if (out_valid !== 1'b1 || out_data !== 16'(i)) begin
                bad++; $display("FAIL ovf_drain%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 16'(i));
            end
            tick();
        end
        out_ready = 0;
        #1 cmp++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got %b want 0", out_valid); end
    endtask

    task automatic test_full_simul();
        logic [15:0] v;
        logic [15:0] exp_seq [4] = '{16'h2, 16'h3, 16'h4, 16'h9};
        for (int i = 1; i <= 4; i++) wr(16'hFF00, 16'(i));
        rw = 0; da = 16'hFF00; tb_dd = 16'h0009; out_ready = 1;
        #1 cmp++;
        if (out_data !== 16'h0001) begin bad++; $display("FAIL full_head got %h want 0001", out_data); end
        tick();
        out_ready = 0; rw = 1; da = 16'hFFFF;
        tick();
        rd(16'hFF01, v);
        cmp++;
        if (v !== 16'h0402) begin bad++; $display("FAIL full_status got %h want 0402", v); end
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1 cmp++;
            if (out_valid !== 1'b1 || out_data !== exp_seq[i]) begin
                bad++; $display("FAIL full_drain%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp_seq[i]);
            end
            tick();
        end
        out_ready = 0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        wr(16'hFF00, 16'h0011);
        wr(16'hFF00, 16'h0022);
        rst = 1; tick(); rst = 0;
        #1 cmp++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
        rd(16'hFF01, v);
        cmp++;
        if (v !== 16'h0001) begin bad++; $display("FAIL rstmid_status got %h want 0001", v); end
        rd(16'h0005, v);
        cmp++;
        if (v !== 16'h1234) begin bad++; $display("FAIL rstmid_ram got %h want 1234", v); end
    endtask

    task automatic test_cycles();
        logic [15:0] v;
`ifdef DBU_CYCLE_COUNTER_EN
        logic [15:0] want [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
`else
        logic [15:0] want [3] = '{16'h0000, 16'h0000, 16'h0000};
`endif
        rw = 0; da = 16'hFF02; tb_dd = 16'hFFFE;
        tick();
        for (int i = 0; i < 3; i++) begin
            rd(16'hFF02, v);
            cmp++;
            if (v !== want[i]) begin bad++; $display("FAIL cycles%0d got %h want %h", i, v, want[i]); end
        end
    endtask

    task automatic test_random();
        logic [15:0] v, e, a;
        for (int n = 0; n < 400; n++) begin
            out_ready = 1'($urandom_range(0, 1));
            #1 cmp++;
            if (out_valid !== (q.size() > 0) || (q.size() > 0 && out_data !== q[0])) begin
                bad++; $display("FAIL rnd_stream n=%0d got v=%b d=%h want v=%b d=%h", n, out_valid, out_data,
                                q.size() > 0, q.size() > 0 ? q[0] : 16'h0);
            end
            case ($urandom_range(0, 7))
                0: wr(16'($urandom_range(0, 255)), 16'($urandom));
                1, 2: wr(16'hFF00, 16'($urandom));
                3: wr(16'hFF01, 16'($urandom));
                4: wr(16'hFF02, 16'($urandom));
                default: begin
                    case ($urandom_range(0, 3))
                        0: a = waddrs.size() > 0 ? 16'(waddrs[$urandom_range(0, waddrs.size() - 1)]) : 16'h0005;
                        1: a = 16'hFF01;
                        2: a = 16'hFF02;
                        default: a = 16'($urandom_range(16'h0100, 16'hFEFF));
                    endcase
                    e = exp_read(a);
                    rd(a, v);
                    cmp++;
                    if (v !== e) begin bad++; $display("FAIL rnd_read n=%0d a=%h got %h want %h", n, a, v, e); end
                end
            endcase
        end
        out_ready = 0;
    endtask

    initial begin
        test_reset();
        test_ram();
        test_single_write();
        test_overflow();
        test_full_simul();
        test_reset_mid();
        test_cycles();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
